// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for the 4x8 register bank: one-entry buffer per requester, round-robin drain.
// Latency: handshake at edge N -> wr_en high in cycle N+2 -> bank write at edge N+2 (2 cycles uncontended).
// Backpressure: reqX_ready = buffer empty or being drained this cycle; both readies low while reset is high.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   req0_valid/ready/addr/data  ALU writeback requester (valid/ready handshake)
//   req1_valid/ready/addr/data  memory-load writeback requester (valid/ready handshake)
//   wr_en, wr_addr, wr_data     registered write port driving the bank's EscreveReg/inec/dado
//   grant                       registered one-hot owner of the current wr_en cycle (bit0=req0, bit1=req1)
//   busy                        either holding buffer is full
//
// Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority
// (req0 always wins a tie, no last pointer; req1 can starve under continuous req0 traffic).

module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,

    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        grant,
    output logic              busy
);

    // One buffered register write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t  buf0_dat;
    wr_t  buf1_dat;
    logic buf0_full;
    logic buf1_full;

    logic sel0;
    logic sel1;
    logic take0;
    logic take1;

    // ------------------------------------------------------------------
    // Arbitration: purely from buffer occupancy (and the last pointer).
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (buf0_full) begin
            sel0 = 1'b1;
        end else if (buf1_full) begin
            sel1 = 1'b1;
        end
    end
`else
    // Index of the requester granted most recently; reset to 1 so req0
    // wins the first tie after reset.
    logic last;

    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (buf0_full && buf1_full) begin
            // Tie: pick the requester that did not win last time.
            sel0 = last;
            sel1 = !last;
        end else begin
            sel0 = buf0_full;
            sel1 = buf1_full;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last <= 1'b1;
        end else if (sel0) begin
            last <= 1'b0;
        end else if (sel1) begin
            last <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Ready: a buffer can accept when empty, or when it is being drained
    // on this same edge (empty-and-reload). Never looks at valid.
    // ------------------------------------------------------------------
    assign req0_ready = !reset && (!buf0_full || sel0);
    assign req1_ready = !reset && (!buf1_full || sel1);

    assign take0 = req0_valid && req0_ready;
    assign take1 = req1_valid && req1_ready;

    // ------------------------------------------------------------------
    // Holding buffers. A new transfer takes precedence over the drain so
    // a drain-plus-reload on the same edge leaves the buffer full with
    // the new contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            buf0_full <= 1'b0;
            buf0_dat  <= '0;
        end else if (take0) begin
            buf0_full <= 1'b1;
            buf0_dat  <= '{addr: req0_addr, data: req0_data};
        end else if (sel0) begin
            buf0_full <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf1_full <= 1'b0;
            buf1_dat  <= '0;
        end else if (take1) begin
            buf1_full <= 1'b1;
            buf1_dat  <= '{addr: req1_addr, data: req1_data};
        end else if (sel1) begin
            buf1_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port. Address/data hold their last value on idle
    // cycles so the bank inputs only toggle on real writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            grant   <= 2'b00;
        end else begin
            wr_en <= sel0 || sel1;
            grant <= {sel1, sel0};
            if (sel0) begin
                wr_addr <= buf0_dat.addr;
                wr_data <= buf0_dat.data;
            end else if (sel1) begin
                wr_addr <= buf1_dat.addr;
                wr_data <= buf1_dat.data;
            end
        end
    end

    assign busy = buf0_full || buf1_full;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: table-driven cycle vectors,
// a contention sequence, and a per-requester scoreboard feeding a bank model.
module tb_regfile_write_arbiter;

    logic       clock;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] grant;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .grant      (grant),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: expected writes queued per requester at handshake time,
    // popped when the DUT presents the matching grant. Bank model follows
    // wr_en exactly as the register bank would.
    // ------------------------------------------------------------------
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [7:0] bank[4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    always @(negedge clock) begin
        logic [9:0] e;
        if (wr_en === 1'b1) begin
            n_tests++;
            if (grant == 2'b01 && q0.size() != 0) begin
                e = q0.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL sb_req0: got %h expected %h", {wr_addr, wr_data}, e);
                end
            end else if (grant == 2'b10 && q1.size() != 0) begin
                e = q1.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL sb_req1: got %h expected %h", {wr_addr, wr_data}, e);
                end
            end else begin
                n_fail++;
                $display("FAIL sb_unexpected_write: grant %b addr %h data %h, no pending write", grant, wr_addr, wr_data);
            end
            bank[wr_addr] = wr_data;
        end
        if (reset === 1'b1) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req0_valid && req0_ready === 1'b1) q0.push_back({req0_addr, req0_data});
            if (req1_valid && req1_ready === 1'b1) q1.push_back({req1_addr, req1_data});
        end
    end

    // ------------------------------------------------------------------
    // Vector table: inputs held for one edge, expected state after it.
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       v0;
        logic [1:0] a0;
        logic [7:0] d0;
        logic       v1;
        logic [1:0] a1;
        logic [7:0] d1;
        logic       en;
        logic [1:0] gnt;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       r0;
        logic       r1;
        logic       bsy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic v0, input logic [1:0] a0, input logic [7:0] d0,
                                input logic v1, input logic [1:0] a1, input logic [7:0] d1,
                                input logic en, input logic [1:0] gnt, input logic [1:0] wa, input logic [7:0] wd,
                                input logic r0, input logic r1, input logic bsy);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.en = en; v.gnt = gnt; v.wa = wa; v.wd = wd; v.r0 = r0; v.r1 = r1; v.bsy = bsy;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic v0, input logic [1:0] a0, input logic [7:0] d0,
                         input logic v1, input logic [1:0] a1, input logic [7:0] d1);
        reset = rst;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    logic [1:0] exp_g[9];
    logic [7:0] d0n, d1n;
    logic       r0s, r1s;

    initial begin
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

        // reset / idle
        vecs[0]  = mk(1, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 0,0,0);
        vecs[1]  = mk(1, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 0,0,0);
        vecs[2]  = mk(0, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 1,1,0);
        // single write req0 -> reg1
        vecs[3]  = mk(0, 1,1,8'h5A, 0,0,8'h00,  0,2'b00,0,8'h00, 1,1,1);
        vecs[4]  = mk(0, 0,0,8'h00, 0,0,8'h00,  1,2'b01,1,8'h5A, 1,1,0);
        vecs[5]  = mk(0, 0,0,8'h00, 0,0,8'h00,  0,2'b00,1,8'h5A, 1,1,0);
        // reset again, then simultaneous requests
        vecs[6]  = mk(1, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 0,0,0);
        vecs[7]  = mk(0, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 1,1,0);
        vecs[8]  = mk(0, 1,2,8'h11, 1,3,8'h22,  0,2'b00,0,8'h00, 1,0,1);
        vecs[9]  = mk(0, 0,0,8'h00, 0,0,8'h00,  1,2'b01,2,8'h11, 1,1,1);
        vecs[10] = mk(0, 0,0,8'h00, 0,0,8'h00,  1,2'b10,3,8'h22, 1,1,0);
        vecs[11] = mk(0, 0,0,8'h00, 0,0,8'h00,  0,2'b00,3,8'h22, 1,1,0);
        // same-address conflict on reg0
        vecs[12] = mk(0, 1,0,8'hAA, 1,0,8'hBB,  0,2'b00,3,8'h22, 1,0,1);
        vecs[13] = mk(0, 0,0,8'h00, 0,0,8'h00,  1,2'b01,0,8'hAA, 1,1,1);
        vecs[14] = mk(0, 0,0,8'h00, 0,0,8'h00,  1,2'b10,0,8'hBB, 1,1,0);
        vecs[15] = mk(0, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'hBB, 1,1,0);
        // both buffers full, then reset: pending data must vanish
        vecs[16] = mk(0, 1,1,8'hC3, 1,2,8'h3C,  0,2'b00,0,8'hBB, 1,0,1);
        vecs[17] = mk(1, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 0,0,0);
        vecs[18] = mk(0, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 1,1,0);
        vecs[19] = mk(0, 0,0,8'h00, 0,0,8'h00,  0,2'b00,0,8'h00, 1,1,0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_wr_en", i),   32'(wr_en),      32'(vecs[i].en));
            chk($sformatf("v%0d_grant", i),   32'(grant),      32'(vecs[i].gnt));
            chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr),    32'(vecs[i].wa));
            chk($sformatf("v%0d_wr_data", i), 32'(wr_data),    32'(vecs[i].wd));
            chk($sformatf("v%0d_ready0", i),  32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("v%0d_ready1", i),  32'(req1_ready), 32'(vecs[i].r1));
            chk($sformatf("v%0d_busy", i),    32'(busy),       32'(vecs[i].bsy));
        end

        // Bank contents: reg0 last written by req1, dropped C3/3C never landed.
        chk("bank_reg0", 32'(bank[0]), 32'h000000BB);
        chk("bank_reg1", 32'(bank[1]), 32'h0000005A);
        chk("bank_reg2", 32'(bank[2]), 32'h00000011);
        chk("bank_reg3", 32'(bank[3]), 32'h00000022);

        // Continuous contention: both valid for 6 edges, data advances on accept.
`ifdef ARB_FIXED_PRIO_EN
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
`else
        exp_g = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
`endif
        d0n = 8'h40;
        d1n = 8'h80;
        for (int k = 0; k < 9; k++) begin
            if (k < 6) drive(1'b0, 1'b1, 2'd1, d0n, 1'b1, 2'd2, d1n);
            else       drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
            r0s = req0_ready;
            r1s = req1_ready;
`ifdef ARB_FIXED_PRIO_EN
            if (k >= 1 && k < 6) chk($sformatf("cont%0d_ready1_starved", k), 32'(r1s), 32'h0);
`endif
            @(posedge clock);
            #1;
            if (k < 6 && r0s) d0n = d0n + 8'd1;
            if (k < 6 && r1s) d1n = d1n + 8'd1;
            chk($sformatf("cont%0d_grant", k), 32'(grant), 32'(exp_g[k]));
        end
`ifdef ARB_FIXED_PRIO_EN
        chk("cont_req0_accepts", 32'(d0n), 32'h46);
        chk("cont_req1_accepts", 32'(d1n), 32'h81);
`else
        chk("cont_req0_accepts", 32'(d0n), 32'h44);
        chk("cont_req1_accepts", 32'(d1n), 32'h83);
`endif
        repeat (2) @(posedge clock);
        #1;
        chk("sb_q0_drained", 32'(q0.size()), 32'h0);
        chk("sb_q1_drained", 32'(q1.size()), 32'h0);
        chk("final_busy",    32'(busy),      32'h0);
`ifdef ARB_FIXED_PRIO_EN
        chk("cont_bank_reg1", 32'(bank[1]), 32'h00000045);
        chk("cont_bank_reg2", 32'(bank[2]), 32'h00000080);
`else
        chk("cont_bank_reg1", 32'(bank[1]), 32'h00000043);
        chk("cont_bank_reg2", 32'(bank[2]), 32'h00000082);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 4x8-bit register bank (`bancoRegs`) between two writeback requesters: req0 (ALU result) and req1 (memory load data).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains at most one buffered write per cycle onto registered `wr_en`/`wr_addr`/`wr_data`. These outputs feed the bank's `EscreveReg`/`inec`/`dado` inputs directly.

Parameters:
- DATA_W, 8, width of write data (matches register width).
- ADDR_W, 2, width of register address (4 registers).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 presents a write.
- req0_ready  output  1  requester 0 write accepted this edge if valid.
- req0_addr  input  ADDR_W  destination register of requester 0.
- req0_data  input  DATA_W  write data of requester 0.
- req1_valid  input  1  requester 1 presents a write.
- req1_ready  output  1  requester 1 write accepted this edge if valid.
- req1_addr  input  ADDR_W  destination register of requester 1.
- req1_data  input  DATA_W  write data of requester 1.
- wr_en  output  1  registered write enable to register bank.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  DATA_W  registered write data.
- grant  output  2  registered one-hot: which requester owns the current wr_en cycle.
- busy  output  1  either holding buffer full.

Behaviour:
- Reset (synchronous, active-high, sampled at the rising edge):
  - clears both buffers; all pending writes are dropped.
  - forces wr_en=0, wr_addr=0, wr_data=0, grant=2'b00.
  - sets the round-robin pointer last=1, so req0 wins the first tie.
  - Reset mid-operation: wr_en is 0 in the cycle after the reset edge. No buffered write survives.
- Buffers:
  - buf_i holds {addr, data} plus a full flag.
  - Transfer occurs on an edge where req_i_valid & req_i_ready.
- Ready:
  - req_i_ready = !buf_i_full | sel_i, where sel_i is this cycle's arbitration pick.
  - Combinational from internal state only; never depends on req_i_valid.
  - Outside reset, a requester that wins every cycle can therefore transfer once per cycle.
  - During reset, both readies are 0.
- Arbitration (combinational, from buffer full flags):
  - Only buf0 full: sel0.
  - Only buf1 full: sel1.
  - Both full: select the requester != last.
  - Neither full: no selection.
  - On a selection edge, last <= selected index.
  - On an edge with no selection, last is held.
- Output register:
  - On each edge, wr_en <= any selection; wr_addr/wr_data <= selected buffer contents; grant <= one-hot of selection.
  - With no selection: wr_en=0, grant=00, and wr_addr/wr_data hold their previous values.
- Buffer update when both happen on the same edge: the selected buffer is emptied and reloaded if a new transfer also occurs. Net result: full, with the new contents.
- Latency:
  - Request accepted at edge N; buffer full during cycle N+1.
  - Earliest grant at edge N+1; wr_en high during cycle N+2.
  - Bank write occurs at edge N+2.
  - Uncontended latency is 2 cycles from handshake to bank write.
- Same-address conflict: both requesters targeting the same register are written in arbitration order. The later grant's data is final. No merging, no dropping.
- Throughput: one bank write per cycle maximum. With both requesters continuously valid, grants alternate 0,1,0,1…
- busy = buf0_full | buf1_full.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority. req0 always wins when both buffers are full; the last pointer is not implemented. req1 can starve while req0 is continuously valid.
- Undefined (default): round-robin as described above.

Test Plan:
1. Reset then idle: reset=1 for 2 edges, all valids 0 -> wr_en=0, grant=00, req0_ready=req1_ready=1, busy=0.
2. Single write: req0 {addr=1, data=8'h5A} valid for one cycle from edge N -> wr_en=1, wr_addr=1, wr_data=8'h5A, grant=01 during cycle N+2 only; bank reg1 reads 8'h5A after.
3. Simultaneous: req0 {2, 8'h11} and req1 {3, 8'h22} accepted on the same edge after reset -> cycle N+2: grant=01, addr=2, data 8'h11; cycle N+3: grant=10, addr=3, data 8'h22; req1_ready=0 during cycle N+1.
4. Continuous contention: both valid for 6 cycles with incrementing data -> grants alternate 01,10,01,10…, no write lost, every accepted datum appears exactly once. With ARB_FIXED_PRIO_EN defined: grant stays 01 and req1_ready stays 0.
5. Same-address conflict: req0 {0, 8'hAA}, req1 {0, 8'hBB} on the same edge -> two writes to reg0 in grant order; final reg0 value = 8'hBB (req1 granted second).
6. Reset mid-operation: both buffers full, reset asserted for one edge -> wr_en=0 in the following cycle, busy=0, no write of the pending data ever appears.
